// File: rtl/drum_sequencer.sv
// Top-level sequencer for the drum-synthesis column array: column reset, iteration
// stepping, sample handshake, strike handling, timeout and profiling (DRUM_SEQ_PROFILE_EN).
module drum_sequencer #(
   parameter int NUM_COLUMNS = 30,
   parameter int DATA_W      = 18,
   parameter int CYC_W       = 13
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     strike,
   input  logic [NUM_COLUMNS-1:0]   col_done,
   input  logic signed [DATA_W-1:0] center_node,
   output logic                     col_reset,
   output logic                     iteration_enable,
   output logic                     sample_valid,
   output logic signed [DATA_W-1:0] sample_data,
   input  logic                     sample_ready,
   output logic                     busy,
   output logic [CYC_W-1:0]         iter_cycles,
   output logic [CYC_W-1:0]         iter_cycles_max,
   output logic                     timeout_err
);

   typedef enum logic [2:0] {COL_RST, LOAD_WAIT, VALID, GUARD, RUN} state_t;

   localparam logic [CYC_W-1:0] CYC_MAX = '1;
   localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (v == CYC_MAX) ? v : v + CYC_ONE;
   endfunction

   state_t             state, state_nx;
   logic               phase, phase_nx;
   logic               strike_pend, pend_nx;
   logic [CYC_W-1:0]   cyc_cnt, cnt_nx;
   logic               enable_nx, latch_sample, latch_iter, timeout_nx;
   logic               all_done, strike_any, timed_out, handshake;

   assign all_done   = &col_done;
   assign strike_any = strike_pend | strike;
   assign timed_out  = (cyc_cnt == CYC_MAX);
   assign handshake  = sample_valid & sample_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= COL_RST;
      else       state <= state_nx;
   end

   // phase doubles as the 2-cycle timer for both COL_RST and GUARD
   always_comb begin
      state_nx     = state;
      phase_nx     = 1'b0;
      pend_nx      = strike_pend;
      cnt_nx       = cyc_cnt;
      enable_nx    = 1'b0;
      latch_sample = 1'b0;
      latch_iter   = 1'b0;
      timeout_nx   = timeout_err;
      case (state)
         COL_RST: begin
            pend_nx = 1'b0;
            if (phase) begin
               state_nx = LOAD_WAIT;
               cnt_nx   = CYC_ONE;
            end else begin
               phase_nx = 1'b1;
            end
         end
         LOAD_WAIT: begin
            cnt_nx = sat_inc(cyc_cnt);
            if (strike) pend_nx = 1'b1;
            if (all_done) begin
               pend_nx = 1'b0;
               if (strike_any) begin
                  state_nx = COL_RST;
               end else begin
                  state_nx     = VALID;
                  latch_sample = 1'b1;
               end
            end else if (timed_out) begin
               pend_nx    = 1'b0;
               timeout_nx = 1'b1;
               state_nx   = COL_RST;
            end
         end
         VALID: begin
            if (strike_any) begin
               pend_nx  = 1'b0;
               state_nx = COL_RST;
            end else if (handshake) begin
               state_nx  = GUARD;
               enable_nx = 1'b1;
               cnt_nx    = CYC_ONE;
            end
         end
         GUARD: begin
            cnt_nx = sat_inc(cyc_cnt);
            if (strike) pend_nx = 1'b1;
            if (phase) state_nx = RUN;
            else       phase_nx = 1'b1;
         end
         RUN: begin
            cnt_nx = sat_inc(cyc_cnt);
            if (strike) pend_nx = 1'b1;
            if (all_done) begin
               latch_iter = 1'b1;
               pend_nx    = 1'b0;
               if (strike_any) begin
                  state_nx = COL_RST;
               end else begin
                  state_nx     = VALID;
                  latch_sample = 1'b1;
               end
            end else if (timed_out) begin
               pend_nx    = 1'b0;
               timeout_nx = 1'b1;
               state_nx   = COL_RST;
            end
         end
         default: state_nx = COL_RST;
      endcase
   end

   // outputs are registered from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (reset) begin
         phase            <= 1'b0;
         strike_pend      <= 1'b0;
         cyc_cnt          <= '0;
         col_reset        <= 1'b1;
         iteration_enable <= 1'b0;
         sample_valid     <= 1'b0;
         sample_data      <= '0;
         busy             <= 1'b0;
         iter_cycles      <= '0;
         timeout_err      <= 1'b0;
      end else begin
         phase            <= phase_nx;
         strike_pend      <= pend_nx;
         cyc_cnt          <= cnt_nx;
         col_reset        <= (state_nx == COL_RST);
         iteration_enable <= enable_nx;
         sample_valid     <= (state_nx == VALID);
         busy             <= (state_nx == GUARD) || (state_nx == RUN);
         timeout_err      <= timeout_nx;
         if (latch_sample) sample_data <= center_node;
         if (latch_iter)   iter_cycles <= cyc_cnt;
      end
   end

`ifdef DRUM_SEQ_PROFILE_EN
   always_ff @(posedge clk) begin
      if (reset)                                     iter_cycles_max <= '0;
      else if (latch_iter && cyc_cnt > iter_cycles_max) iter_cycles_max <= cyc_cnt;
   end
`else
   assign iter_cycles_max = '0;
`endif

endmodule
